rx_release_ctrl: RTL and testbench
==================================

Name: rx_release_ctrl

Overview:
Frame-level release scheduler for the receive path, placed between the demapper, the UART TX payload FIFO and the serial receiver/ACK transmitter.
- Counts the payload bytes of each frame as they enter the FIFO.
- Holds UART transmission until the frame's CRC verdict arrives.
- On a good CRC it releases the frame to the UART and requests an ACK.
- On a bad CRC or a verdict timeout it flushes the FIFO and requests a NAK, bounded by a retry limit.
- With ARQ disabled it passes everything through.

Parameters:
CNT_W, 12, width of the per-frame byte counters (max frame payload 4095 bytes)
FLUSH_CYCLES, 40, cycles o_fifo_flush is held asserted (covers FIFO reset recovery)
TIMEOUT_CYCLES, 4096, idle cycles after the last byte before a missing verdict counts as an error
MAX_RETRY, 3, consecutive NAKs allowed before the frame is dropped

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_pyld_valid  in  1  demapper payload byte valid (FIFO write side)
i_pyld_ready  in  1  FIFO write ready
i_tx_valid  in  1  FIFO read-side valid to the UART
i_tx_ready  in  1  UART ready
i_crc_err  in  1  CRC verdict, 1 = error
i_crc_err_valid  in  1  verdict strobe
i_arq_en  in  1  ARQ mode from the frame header
i_arq_en_valid  in  1  ARQ mode strobe
o_uart_tx_en  out  1  UART transmit enable
o_fifo_flush  out  1  active-high FIFO flush
o_ack  out  1  one-cycle ACK request to the ACK transmitter
o_nak  out  1  one-cycle NAK request
o_drop  out  1  one-cycle pulse when a frame is abandoned
o_retry_cnt  out  2  current consecutive retry count
o_state  out  3  encoded FSM state, for debug LEDs

Behaviour:
Reset (asynchronous; all outputs and registers):
- State = IDLE, arq_mode = 1, counters = 0.
- o_uart_tx_en = 0, o_fifo_flush = 1, o_ack/o_nak/o_drop = 0, o_retry_cnt = 0.

ARQ mode latching:
- arq_mode loads from i_arq_en on i_arq_en_valid, but only in IDLE or PASS.
- A strobe arriving in any other state is captured as pending and applied on the next entry to IDLE.

Byte accounting:
- in_cnt increments on i_pyld_valid & i_pyld_ready.
- out_cnt increments on i_tx_valid & i_tx_ready.
- Both saturate at 2^CNT_W-1 and clear on entry to IDLE.

States and encoding for o_state:
- IDLE (0)
  - o_uart_tx_en = 0, o_fifo_flush = 0.
  - If arq_mode = 0, go to PASS.
  - Otherwise the first accepted byte moves to COLLECT; that byte is counted.
- COLLECT (1)
  - The timeout counter restarts on every accepted byte.
  - i_crc_err_valid & !i_crc_err goes to RELEASE, with a one-cycle o_ack on the transition cycle.
  - i_crc_err_valid & i_crc_err, or the timeout counter reaching TIMEOUT_CYCLES-1, goes to FLUSH.
  - A byte and a verdict in the same cycle: the byte is counted, then the transition happens.
- RELEASE (2)
  - o_uart_tx_en = 1.
  - Exits to IDLE once out_cnt == in_cnt, including the cycle of the final handshake. retry_cnt clears on exit.
  - An empty frame (in_cnt = 0) exits on the next cycle.
- FLUSH (3)
  - o_fifo_flush = 1 for exactly FLUSH_CYCLES cycles; o_uart_tx_en = 0.
  - Byte counting is ignored while flushing.
  - Then go to NAK.
- NAK (4)
  - Lasts one cycle.
  - If retry_cnt < MAX_RETRY: o_nak = 1, retry_cnt increments, go to IDLE.
  - Otherwise: o_drop = 1, retry_cnt = 0, go to IDLE.
- PASS (5)
  - o_uart_tx_en = 1; verdicts are ignored and no flush, ACK or NAK is issued.
  - An ARQ strobe with i_arq_en = 1 goes to IDLE.
- Encodings 6 and 7 are unused and recover to IDLE.

Verdict outside COLLECT: ignored, except in IDLE with arq_mode = 1, where an error verdict goes to FLUSH (a frame with a corrupt header and no payload).

Optional Feature:
RX_REL_STATS_EN
- Defined: adds o_good_cnt [15:0], o_err_cnt [15:0] and o_drop_cnt [15:0].
  - Incremented on an o_ack transition, on FLUSH entry and on o_drop respectively.
  - Saturating; reset to 0.
- Undefined: these ports and their registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package rx_ctrl_pkg holds:
  - the state encoding constants (IDLE..PASS);
  - FLUSH_CYCLES_DEF = 40 and MAX_RETRY_DEF = 3, reused by the receiver top level.
- One natural sub-module, rx_rel_timer: a loadable down-counter with a done flag. It is instanced twice, once for the flush hold and once for the verdict timeout.

Test Plan:
1. ARQ on, 16 bytes in, good verdict, UART drains 16 bytes -> o_ack pulses once; o_uart_tx_en is high only in RELEASE; state returns to IDLE on the 16th output handshake; retry_cnt = 0.
2. ARQ on, 10 bytes in, bad verdict -> o_fifo_flush is high for exactly 40 cycles; o_nak pulses; retry_cnt = 1; zero bytes are released to the UART.
3. Four consecutive bad frames -> o_nak on frames 1-3 (retry_cnt 1, 2, 3); frame 4 gives o_drop with no o_nak and retry_cnt = 0.
4. ARQ off strobe in IDLE -> PASS with o_uart_tx_en = 1; 8 bytes plus bad verdicts -> no flush, ACK or NAK; an ARQ-on strobe returns to IDLE.
5. 5 bytes then silence with TIMEOUT_CYCLES = 64 -> FLUSH entered 64 cycles after the last byte; then o_nak.
6. Assert i_rst_n low mid-RELEASE, between clock edges -> outputs take reset values immediately (o_fifo_flush = 1, o_uart_tx_en = 0); after release, a normal 4-byte good frame completes.

Source files
------------

// File: rtl/rx_ctrl_pkg.sv
// Shared receive-control definitions: FSM state encoding and defaults reused by the receiver top level.
package rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_RELEASE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_NAK     = 3'd4,
    ST_PASS    = 3'd5
  } rx_state_e;

  localparam int FLUSH_CYCLES_DEF = 40;
  localparam int MAX_RETRY_DEF    = 3;

endpackage

// File: rtl/rx_rel_timer.sv
// Loadable down-counter with a done flag; used for the flush hold and the verdict timeout.
module rx_rel_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/rx_release_ctrl.sv
// Frame release scheduler: holds UART output until the CRC verdict, then releases (ACK) or
// flushes (NAK / drop). Defining RX_REL_STATS_EN adds saturating good/error/drop frame counters.
module rx_release_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int CNT_W          = 12,
  parameter int FLUSH_CYCLES   = FLUSH_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = MAX_RETRY_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pyld_valid,
  input  logic        i_pyld_ready,
  input  logic        i_tx_valid,
  input  logic        i_tx_ready,
  input  logic        i_crc_err,
  input  logic        i_crc_err_valid,
  input  logic        i_arq_en,
  input  logic        i_arq_en_valid,
  output logic        o_uart_tx_en,
  output logic        o_fifo_flush,
  output logic        o_ack,
  output logic        o_nak,
  output logic        o_drop,
  output logic [1:0]  o_retry_cnt,
  output logic [2:0]  o_state
`ifdef RX_REL_STATS_EN
  ,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_drop_cnt
`endif
);

  localparam int                TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int                FL_W      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FL_W-1:0]   FL_LOAD   = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [1:0]        RETRY_LIM = 2'(MAX_RETRY);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             arq_mode_q, arq_mode_d;
  logic             arq_pend_q, arq_pend_d, arq_pend_val_q, arq_pend_val_d;
  logic             flush_q;
  logic             in_acc, out_acc, to_done, fl_done, idle_entry, flush_entry;

  assign in_acc      = i_pyld_valid & i_pyld_ready;
  assign out_acc     = i_tx_valid & i_tx_ready;
  assign idle_entry  = (state_d == ST_IDLE) && (state_q != ST_IDLE);
  assign flush_entry = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);

  // Every accepted byte reloads the timeout; it only runs while collecting.
  rx_rel_timer #(.W(TO_W)) u_timeout (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .load_i     (in_acc),
    .load_val_i (TO_LOAD),
    .en_i       (state_q == ST_COLLECT),
    .done_o     (to_done)
  );

  rx_rel_timer #(.W(FL_W)) u_flush (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .load_i     (flush_entry),
    .load_val_i (FL_LOAD),
    .en_i       (state_q == ST_FLUSH),
    .done_o     (fl_done)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (state_q != ST_FLUSH) begin
      if (in_acc && in_cnt_q != CNT_MAX)   in_cnt_d  = in_cnt_q + CNT_W'(1);
      if (out_acc && out_cnt_q != CNT_MAX) out_cnt_d = out_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    o_ack   = 1'b0;
    o_nak   = 1'b0;
    o_drop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!arq_mode_q)                       state_d = ST_PASS;
        else if (i_crc_err_valid && i_crc_err) state_d = ST_FLUSH;
        else if (in_acc)                       state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (i_crc_err_valid && !i_crc_err) begin
          state_d = ST_RELEASE;
          o_ack   = 1'b1;
        end else if (i_crc_err_valid || (to_done && !in_acc)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_RELEASE: begin
        // Compare post-update counts so the final handshake cycle exits.
        if (out_cnt_d == in_cnt_d) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      ST_FLUSH: if (fl_done) state_d = ST_NAK;
      ST_NAK: begin
        state_d = ST_IDLE;
        if (retry_q < RETRY_LIM) begin
          o_nak   = 1'b1;
          retry_d = retry_q + 2'd1;
        end else begin
          o_drop  = 1'b1;
          retry_d = '0;
        end
      end
      ST_PASS: if (i_arq_en_valid && i_arq_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Mode changes mid-frame are parked and applied when the frame finishes.
  always_comb begin
    arq_mode_d     = arq_mode_q;
    arq_pend_d     = arq_pend_q;
    arq_pend_val_d = arq_pend_val_q;
    if (i_arq_en_valid) begin
      if (state_q == ST_IDLE || state_q == ST_PASS) begin
        arq_mode_d = i_arq_en;
      end else begin
        arq_pend_d     = 1'b1;
        arq_pend_val_d = i_arq_en;
      end
    end
    if (idle_entry && arq_pend_d) begin
      arq_mode_d = arq_pend_val_d;
      arq_pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_IDLE;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      retry_q        <= '0;
      arq_mode_q     <= 1'b1;
      arq_pend_q     <= 1'b0;
      arq_pend_val_q <= 1'b0;
      flush_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      in_cnt_q       <= idle_entry ? '0 : in_cnt_d;
      out_cnt_q      <= idle_entry ? '0 : out_cnt_d;
      retry_q        <= retry_d;
      arq_mode_q     <= arq_mode_d;
      arq_pend_q     <= arq_pend_d;
      arq_pend_val_q <= arq_pend_val_d;
      flush_q        <= (state_d == ST_FLUSH);
    end
  end

  assign o_uart_tx_en = (state_q == ST_RELEASE) || (state_q == ST_PASS);
  assign o_fifo_flush = flush_q;
  assign o_retry_cnt  = retry_q;
  assign o_state      = state_q;

`ifdef RX_REL_STATS_EN
  logic [15:0] good_q, err_q, drop_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      good_q <= '0;
      err_q  <= '0;
      drop_q <= '0;
    end else begin
      if (o_ack && good_q != '1)       good_q <= good_q + 16'd1;
      if (flush_entry && err_q != '1)  err_q  <= err_q + 16'd1;
      if (o_drop && drop_q != '1)      drop_q <= drop_q + 16'd1;
    end
  end

  assign o_good_cnt = good_q;
  assign o_err_cnt  = err_q;
  assign o_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_rx_release_ctrl.sv
// Self-checking bench for rx_release_ctrl: a frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rx_release_ctrl;

  localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_RELEASE = 2, PH_FLUSH = 3, PH_NAK = 4, PH_PASS = 5;
  localparam int TO = 64, FL = 40, MAXR = 3, CMAX = 4095;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pyld_valid = 0, pyld_ready = 0, tx_valid = 0, tx_ready = 0;
  logic crc_err = 0, crc_err_valid = 0, arq_en = 0, arq_en_valid = 0;
  logic o_uart_tx_en, o_fifo_flush, o_ack, o_nak, o_drop;
  logic [1:0] o_retry_cnt;
  logic [2:0] o_state;
`ifdef RX_REL_STATS_EN
  logic [15:0] o_good_cnt, o_err_cnt, o_drop_cnt;
`endif

  always #5 clk = ~clk;

  rx_release_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pyld_valid    (pyld_valid),
    .i_pyld_ready    (pyld_ready),
    .i_tx_valid      (tx_valid),
    .i_tx_ready      (tx_ready),
    .i_crc_err       (crc_err),
    .i_crc_err_valid (crc_err_valid),
    .i_arq_en        (arq_en),
    .i_arq_en_valid  (arq_en_valid),
    .o_uart_tx_en    (o_uart_tx_en),
    .o_fifo_flush    (o_fifo_flush),
    .o_ack           (o_ack),
    .o_nak           (o_nak),
    .o_drop          (o_drop),
    .o_retry_cnt     (o_retry_cnt),
    .o_state         (o_state)
`ifdef RX_REL_STATS_EN
    ,
    .o_good_cnt      (o_good_cnt),
    .o_err_cnt       (o_err_cnt),
    .o_drop_cnt      (o_drop_cnt)
`endif
  );

  int n_checks = 0, n_errors = 0;
  int n_ack = 0, n_nak = 0, n_drop = 0, n_flush_cyc = 0, n_tx_hs = 0;
  int fifo_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame phase, byte totals, quiet time since the last byte, flush time left.
  int m_phase, m_in, m_out, m_quiet, m_flush_left, m_retry;
  bit m_arq, m_pend, m_pend_val, m_flush_out;

  task automatic m_reset();
    m_phase = PH_IDLE; m_arq = 1; m_pend = 0; m_pend_val = 0;
    m_in = 0; m_out = 0; m_quiet = 0; m_flush_left = 0; m_retry = 0; m_flush_out = 1;
  endtask

  task automatic m_step();
    int np;
    bit b_in, b_out;
    b_in  = pyld_valid && pyld_ready;
    b_out = tx_valid && tx_ready;
    np = m_phase;
    if (m_phase != PH_FLUSH) begin
      if (b_in && m_in < CMAX)   m_in++;
      if (b_out && m_out < CMAX) m_out++;
    end
    case (m_phase)
      PH_IDLE: begin
        if (!m_arq) np = PH_PASS;
        else if (crc_err_valid && crc_err) np = PH_FLUSH;
        else if (b_in) begin np = PH_COLLECT; m_quiet = 0; end
      end
      PH_COLLECT: begin
        if (crc_err_valid && !crc_err) np = PH_RELEASE;
        else if (crc_err_valid || (!b_in && m_quiet == TO - 1)) np = PH_FLUSH;
        m_quiet = b_in ? 0 : m_quiet + 1;
      end
      PH_RELEASE: if (m_out == m_in) begin np = PH_IDLE; m_retry = 0; end
      PH_FLUSH: begin
        m_flush_left--;
        if (m_flush_left == 0) np = PH_NAK;
      end
      PH_NAK: begin
        m_retry = (m_retry < MAXR) ? m_retry + 1 : 0;
        np = PH_IDLE;
      end
      PH_PASS: if (arq_en_valid && arq_en) np = PH_IDLE;
      default: np = PH_IDLE;
    endcase
    if (np == PH_FLUSH && m_phase != PH_FLUSH) m_flush_left = FL;
    if (arq_en_valid) begin
      if (m_phase == PH_IDLE || m_phase == PH_PASS) m_arq = arq_en;
      else begin m_pend = 1; m_pend_val = arq_en; end
    end
    if (np == PH_IDLE && m_phase != PH_IDLE) begin
      m_in = 0; m_out = 0;
      if (m_pend) begin m_arq = m_pend_val; m_pend = 0; end
    end
    m_flush_out = (np == PH_FLUSH);
    m_phase = np;
  endtask

  logic [9:0] exp_v, act_v;

  always @(negedge clk) begin
    if (!rst_n) m_reset();
    exp_v = {3'(m_phase), 2'(m_retry),
             (m_phase == PH_RELEASE || m_phase == PH_PASS), m_flush_out,
             (m_phase == PH_COLLECT && crc_err_valid && !crc_err),
             (m_phase == PH_NAK && m_retry < MAXR),
             (m_phase == PH_NAK && m_retry >= MAXR)};
    act_v = {o_state, o_retry_cnt, o_uart_tx_en, o_fifo_flush, o_ack, o_nak, o_drop};
    check("state/retry/txen/flush/ack/nak/drop", {22'd0, act_v}, {22'd0, exp_v});
    if (rst_n) begin
      m_step();
      n_ack       += int'(o_ack);
      n_nak       += int'(o_nak);
      n_drop      += int'(o_drop);
      n_flush_cyc += int'(o_fifo_flush);
      n_tx_hs     += int'(tx_valid && tx_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    {pyld_valid, pyld_ready, tx_valid, tx_ready, crc_err, crc_err_valid, arq_en, arq_en_valid} = '0;
    fifo_cnt = 0;
    repeat (2) tick();
    rst_n = 1;
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      pyld_valid = 1; pyld_ready = 1;
      tick();
      fifo_cnt++;
    end
    pyld_valid = 0; pyld_ready = 0;
  endtask

  task automatic verdict(input logic err);
    crc_err_valid = 1; crc_err = err;
    tick();
    crc_err_valid = 0; crc_err = 0;
  endtask

  task automatic arq_strobe(input logic en);
    arq_en_valid = 1; arq_en = en;
    tick();
    arq_en_valid = 0; arq_en = 0;
  endtask

  // Acts as the FIFO read side: offers bytes only while the UART is enabled.
  task automatic run_until_idle(input int max_cyc, input string tag);
    bit done;
    done = 0;
    for (int k = 0; k < max_cyc; k++) begin
      if (o_fifo_flush) fifo_cnt = 0;
      tx_valid = (fifo_cnt > 0) && o_uart_tx_en;
      tx_ready = 1;
      tick();
      if (tx_valid) fifo_cnt--;
      if (o_state == 3'd0) begin done = 1; break; end
    end
    tx_valid = 0; tx_ready = 0;
    check({tag, " reached IDLE"}, 32'(done), 32'd1);
  endtask

  int b_ack, b_nak, b_drop, b_fl, b_tx, wait_k;
  int exp_retry[4] = '{1, 2, 3, 0};

  initial begin
    do_reset();
    check("reset flush", 32'(o_fifo_flush), 32'd1);
    tick();
    check("idle after reset", {o_state, o_uart_tx_en, o_fifo_flush}, 32'd0);

    // 1: good frame of 16 bytes
    b_ack = n_ack; b_tx = n_tx_hs;
    send_bytes(16);
    check("t1 collect", 32'(o_state), 32'd1);
    verdict(0);
    check("t1 release txen", {o_state, o_uart_tx_en}, {28'd0, 3'd2, 1'b1});
    run_until_idle(100, "t1");
    check("t1 ack count", n_ack - b_ack, 32'd1);
    check("t1 bytes out", n_tx_hs - b_tx, 32'd16);
    check("t1 retry", 32'(o_retry_cnt), 32'd0);

    // 2: bad frame of 10 bytes
    b_nak = n_nak; b_fl = n_flush_cyc; b_tx = n_tx_hs;
    send_bytes(10);
    verdict(1);
    run_until_idle(100, "t2");
    check("t2 flush cycles", n_flush_cyc - b_fl, 32'd40);
    check("t2 nak count", n_nak - b_nak, 32'd1);
    check("t2 retry", 32'(o_retry_cnt), 32'd1);
    check("t2 bytes out", n_tx_hs - b_tx, 32'd0);

    // 3: four consecutive bad frames from a clean start
    do_reset();
    for (int f = 0; f < 4; f++) begin
      b_nak = n_nak; b_drop = n_drop;
      send_bytes(3);
      verdict(1);
      run_until_idle(100, "t3");
      check("t3 retry", 32'(o_retry_cnt), 32'(exp_retry[f]));
      check("t3 nak", n_nak - b_nak, 32'(f < 3));
      check("t3 drop", n_drop - b_drop, 32'(f == 3));
    end

    // 4: ARQ off passes everything through
    arq_strobe(0);
    tick();
    check("t4 pass", {o_state, o_uart_tx_en}, {28'd0, 3'd5, 1'b1});
    b_ack = n_ack; b_nak = n_nak; b_fl = n_flush_cyc;
    for (int i = 0; i < 8; i++) begin
      pyld_valid = 1; pyld_ready = 1; tx_valid = 1; tx_ready = 1;
      crc_err_valid = i[0]; crc_err = 1;
      tick();
    end
    {pyld_valid, pyld_ready, tx_valid, tx_ready, crc_err_valid, crc_err} = '0;
    check("t4 still pass", 32'(o_state), 32'd5);
    check("t4 no ack/nak/flush", (n_ack - b_ack) + (n_nak - b_nak) + (n_flush_cyc - b_fl), 32'd0);
    arq_strobe(1);
    check("t4 back idle", {o_state, o_uart_tx_en}, 32'd0);

    // 5: verdict timeout after 5 bytes
    do_reset();
    b_nak = n_nak;
    send_bytes(5);
    wait_k = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (o_state == 3'd3) begin wait_k = k; break; end
    end
    check("t5 timeout cycles", 32'(wait_k), 32'd64);
    run_until_idle(100, "t5");
    check("t5 nak", n_nak - b_nak, 32'd1);

    // 6: asynchronous reset in the middle of a release
    send_bytes(6);
    verdict(0);
    tx_valid = 1; tx_ready = 1;
    tick(); tick();
    tx_valid = 0; tx_ready = 0;
    check("t6 in release", 32'(o_state), 32'd2);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("t6 async reset", {o_state, o_uart_tx_en, o_fifo_flush, o_retry_cnt}, 32'b0000100);
    fifo_cnt = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    b_ack = n_ack; b_tx = n_tx_hs;
    send_bytes(4);
    verdict(0);
    run_until_idle(100, "t6");
    check("t6 ack", n_ack - b_ack, 32'd1);
    check("t6 bytes out", n_tx_hs - b_tx, 32'd4);

    // 7: error verdict with no payload, with an ARQ-off strobe parked during the flush
    b_nak = n_nak;
    verdict(1);
    check("t7 flush entry", {o_state, o_fifo_flush}, {28'd0, 3'd3, 1'b1});
    arq_strobe(0);
    run_until_idle(100, "t7");
    check("t7 nak", n_nak - b_nak, 32'd1);
    tick();
    check("t7 pending applied", 32'(o_state), 32'd5);
    arq_strobe(1);
    check("t7 idle", 32'(o_state), 32'd0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
